avalon_timer_mc: RTL and testbench
==================================

AVALON_TIMER_MC -- requirements
Module: avalon_timer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 SHALL have parameter DEFAULT_PERIOD, default 49999, reset value of every period register and counter.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port address, input, $clog2(NUM_CH)+3, word address: upper bits channel, low 3 bits register.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, registered read data.
REQ-011 SHALL have port irq_vec, output, NUM_CH, per-channel interrupt.
REQ-012 SHALL have port irq, output, 1, OR of irq_vec.

Function
REQ-013 Register map per channel SHALL be: 0 status {RUN bit1, TO bit0}, 1 control {STOP bit3, START bit2, CONT bit1, ITO bit0}, 2 period, 3 snapshot, 4 prescale; offsets 5-7 read 0.
REQ-014 Reads SHALL have one-cycle latency, readdata updated every clock from the address mux regardless of chipselect; unmapped channel or offset reads 0.
REQ-015 Writes (chipselect && !write_n) to channel >= NUM_CH or offsets 5-7 SHALL be ignored.
REQ-016 Control write SHALL store bits [3:0]; START=1 sets RUN next cycle; STOP=1 clears RUN; START and STOP both 1: START wins.
REQ-017 Period write SHALL store writedata[CNT_W-1:0], clear RUN, and load the counter with the new period on the following cycle (force-reload).
REQ-018 While RUN and tick, counter SHALL decrement by 1; at zero on tick it SHALL reload period, set TO, and clear RUN when CONT=0.
REQ-019 Period 0 SHALL yield TO on every tick while running; no underflow wrap below 0.
REQ-020 Any write to status SHALL clear TO; clear and new timeout in same cycle: clear wins.
REQ-021 Write to snapshot SHALL capture the live counter into snapshot register; read returns zero-extended value.
REQ-022 irq_vec[i] SHALL equal TO[i] && ITO[i]; irq combinational from irq_vec.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-024 On reset_n low: counters and periods = DEFAULT_PERIOD, control/TO/RUN/snapshot = 0, prescale = 0, readdata = 0, irq = 0.
REQ-025 Reset mid-count SHALL abort immediately; no timeout is generated on release.

Configuration
REQ-026 With TIMER_PRESCALER_EN defined, each channel SHALL have an 8-bit prescale register P; tick asserts once per P+1 clocks; prescale divider resets to 0 on START or period write.
REQ-027 Without TIMER_PRESCALER_EN, tick SHALL be 1 every clock, prescale register reads 0, writes ignored.

Structure
REQ-028 Package timer_mc_pkg SHALL hold register offset constants, control/status bit positions and the prescaler width.
REQ-029 One sub-module timer_channel SHALL implement counter, prescaler, control, TO and snapshot for one channel, instantiated NUM_CH times; top holds decode and read mux.

Verification
REQ-030 Ch0 period=9, control=0x6 (START|CONT) -> TO every 10 clocks, RUN stays 1, irq_vec[0]=0 until ITO set.
REQ-031 Ch2 period=4, control=0x5 (START|ITO, one-shot) -> TO and irq after 5 clocks, RUN=0; status write -> irq=0 next cycle.
REQ-032 Ch1 running, control=0x8 -> RUN=0, counter frozen; snapshot write twice 10 clocks apart -> equal values.
REQ-033 Prescale=3 on ch3, period=1, START|CONT (macro defined) -> TO every 8 clocks; macro undefined -> every 2 clocks.
REQ-034 Write address of channel NUM_CH and offset 6 -> no state change, readback 0; assert reset_n mid-count -> all registers at reset values.

Source files
------------

// File: rtl/timer_mc_pkg.sv
// Shared register offsets, control/status bit positions and prescaler width
// for the multi-channel Avalon timer.
package timer_mc_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_SNAPSHOT = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int PRESC_W = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with reload, control/TO flags, snapshot and
// optional prescaler (enabled with TIMER_PRESCALER_EN).
module timer_channel
  import timer_mc_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_off,
  input  logic [31:0]        wdata,
  output logic               run,
  output logic               to,
  output logic [3:0]         ctrl,
  output logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   snap,
  output logic [PRESC_W-1:0] presc,
  output logic               irq
);

  logic [CNT_W-1:0] cnt;
  logic             tick;

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pdiv;
  logic               restart;

  assign restart = wr_en && (wr_off == OFF_PERIOD ||
                             (wr_off == OFF_CONTROL && wdata[CTL_START]));
  // >= keeps the divider from spinning a full wrap if P is lowered mid-count
  assign tick  = (pdiv >= presc_q);
  assign presc = presc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      pdiv    <= '0;
    end else begin
      if (wr_en && wr_off == OFF_PRESCALE) presc_q <= wdata[PRESC_W-1:0];
      if (restart) pdiv <= '0;
      else if (run) pdiv <= tick ? '0 : pdiv + PRESC_W'(1);
    end
  end
`else
  assign tick  = 1'b1;
  assign presc = '0;
`endif

  assign irq = to & ctrl[CTL_ITO];

  // Bus writes come last so they override same-cycle counting effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= CNT_W'(DEFAULT_PERIOD);
      period <= CNT_W'(DEFAULT_PERIOD);
      run    <= 1'b0;
      to     <= 1'b0;
      ctrl   <= '0;
      snap   <= '0;
    end else begin
      if (run && tick) begin
        if (cnt == '0) begin
          cnt <= period;
          to  <= 1'b1;
          if (!ctrl[CTL_CONT]) run <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
      if (wr_en) begin
        case (wr_off)
          OFF_STATUS:   to <= 1'b0;
          OFF_CONTROL: begin
            ctrl <= wdata[3:0];
            if (wdata[CTL_START])     run <= 1'b1;
            else if (wdata[CTL_STOP]) run <= 1'b0;
          end
          OFF_PERIOD: begin
            period <= wdata[CNT_W-1:0];
            cnt    <= wdata[CNT_W-1:0];
            run    <= 1'b0;
          end
          OFF_SNAPSHOT: snap <= cnt;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/avalon_timer_mc.sv
// Multi-channel Avalon-MM timer: address decode, registered read mux and IRQ
// combine. Prescaler per channel is built only with TIMER_PRESCALER_EN.
module avalon_timer_mc
  import timer_mc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic                       irq
);

  localparam int AW   = $clog2(NUM_CH) + 3;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW-1:0] NUM_CH_A = AW'(NUM_CH);

  logic [AW-1:0]   ch_idx;
  logic [CH_W-1:0] ch_sel;
  logic [2:0]      offset;
  logic            ch_valid;
  logic            wr_hit;
  logic [31:0]     rd_mux;

  logic [NUM_CH-1:0]  run_v;
  logic [NUM_CH-1:0]  to_v;
  logic [3:0]         ctrl_v   [NUM_CH];
  logic [CNT_W-1:0]   period_v [NUM_CH];
  logic [CNT_W-1:0]   snap_v   [NUM_CH];
  logic [PRESC_W-1:0] presc_v  [NUM_CH];

  // Full-width channel index so addresses past NUM_CH are never aliased.
  assign ch_idx   = address >> 3;
  assign ch_sel   = ch_idx[CH_W-1:0];
  assign offset   = address[2:0];
  assign ch_valid = (ch_idx < NUM_CH_A);
  assign wr_hit   = chipselect && !write_n && ch_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_hit && (ch_sel == CH_W'(i))),
      .wr_off  (offset),
      .wdata   (writedata),
      .run     (run_v[i]),
      .to      (to_v[i]),
      .ctrl    (ctrl_v[i]),
      .period  (period_v[i]),
      .snap    (snap_v[i]),
      .presc   (presc_v[i]),
      .irq     (irq_vec[i])
    );
  end

  assign irq = |irq_vec;

  always_comb begin
    rd_mux = '0;
    if (ch_valid) begin
      case (offset)
        OFF_STATUS: begin
          rd_mux[ST_RUN] = run_v[ch_sel];
          rd_mux[ST_TO]  = to_v[ch_sel];
        end
        OFF_CONTROL:  rd_mux = 32'(ctrl_v[ch_sel]);
        OFF_PERIOD:   rd_mux = 32'(period_v[ch_sel]);
        OFF_SNAPSHOT: rd_mux = 32'(snap_v[ch_sel]);
        OFF_PRESCALE: rd_mux = 32'(presc_v[ch_sel]);
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_avalon_timer_mc.sv
// Directed self-checking bench for avalon_timer_mc (5 channels, 16-bit counters).
module tb_avalon_timer_mc;

  localparam int NUM_CH         = 5;
  localparam int CNT_W          = 16;
  localparam int DEFAULT_PERIOD = 49999;
  localparam int AW             = 6;

`ifdef TIMER_PRESCALER_EN
  localparam int EXP_PS    = 8;
  localparam int EXP_PRESC = 3;
`else
  localparam int EXP_PS    = 2;
  localparam int EXP_PRESC = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_timer_mc #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input int ch, input int off, input logic [31:0] data);
    @(negedge clk);
    address    = AW'(ch * 8 + off);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int off, output logic [31:0] data);
    @(negedge clk);
    address = AW'(ch * 8 + off);
    @(posedge clk);
    #1 data = readdata;
  endtask

  // Polls the status register; TO is seen one clock after it is set.
  task automatic wait_to(input int ch, input int budget, output int t, output logic [31:0] st);
    logic found;
    found   = 1'b0;
    t       = cyc;
    st      = '0;
    address = AW'(ch * 8);
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (readdata[0]) begin
        found = 1'b1;
        t     = cyc;
        st    = readdata;
      end
    end
    check("wait_to_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_irq(input int ch, input int budget, output int t);
    logic found;
    found = 1'b0;
    t     = cyc;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (irq_vec[ch]) begin
        found = 1'b1;
        t     = cyc;
      end
    end
    check("wait_irq_seen", 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] st;
    int t0, t1, t2;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    bus_read(0, 0, rd); check("rst_status", rd, 32'd0);
    bus_read(0, 1, rd); check("rst_control", rd, 32'd0);
    bus_read(0, 2, rd); check("rst_period", rd, 32'd49999);
    bus_read(0, 3, rd); check("rst_snapshot", rd, 32'd0);
    bus_read(3, 4, rd); check("rst_prescale", rd, 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);

    // ch0: period 9, START|CONT -> timeout every 10 clocks, stays running
    bus_write(0, 2, 9);
    bus_write(0, 1, 32'h6);
    t0 = cyc;
    wait_to(0, 40, t1, st);
    check("c0_first_to_plus_rdlat", 32'(t1 - t0), 32'd11);
    check("c0_status_run_to", st, 32'd3);
    check("c0_irq_masked", 32'(irq_vec[0]), 32'd0);
    bus_write(0, 0, 0);
    wait_to(0, 40, t2, st);
    check("c0_to_interval", 32'(t2 - t1), 32'd10);
    bus_write(0, 1, 32'h3);
    check("c0_irq_after_ito", 32'(irq_vec[0]), 32'd1);
    check("c0_irq_top", 32'(irq), 32'd1);
    bus_read(0, 0, rd); check("c0_still_running", rd[1], 1'b1);
    bus_write(0, 1, 32'h8);
    bus_write(0, 0, 0);
    bus_read(0, 0, rd); check("c0_stopped_clear", rd, 32'd0);
    check("c0_irq_gone", 32'(irq), 32'd0);

    // ch2: period 4, one-shot with ITO -> irq after 5 clocks, RUN drops
    bus_write(2, 2, 4);
    bus_write(2, 1, 32'h5);
    t0 = cyc;
    wait_irq(2, 20, t1);
    check("c2_irq_latency", 32'(t1 - t0), 32'd5);
    check("c2_irq_top", 32'(irq), 32'd1);
    bus_read(2, 0, rd); check("c2_status_oneshot", rd, 32'd1);
    bus_write(2, 0, 0);
    check("c2_irq_vec_cleared", 32'(irq_vec[2]), 32'd0);
    check("c2_irq_cleared", 32'(irq), 32'd0);

    // ch1: stop after 21 decrements from 100 -> counter frozen at 79
    bus_write(1, 2, 100);
    bus_write(1, 1, 32'h4);
    repeat (20) @(posedge clk);
    bus_write(1, 1, 32'h8);
    bus_write(1, 3, 0);
    bus_read(1, 3, rd); check("c1_snap_first", rd, 32'd79);
    repeat (10) @(posedge clk);
    bus_write(1, 3, 0);
    bus_read(1, 3, rd); check("c1_snap_frozen", rd, 32'd79);
    bus_read(1, 0, rd); check("c1_status_stopped", rd, 32'd0);
    bus_read(1, 1, rd); check("c1_control_stored", rd, 32'd8);

    // ch3: prescale 3, period 1, START|CONT|ITO
    bus_write(3, 4, 3);
    bus_write(3, 2, 1);
    bus_write(3, 1, 32'h7);
    t0 = cyc;
    wait_irq(3, 40, t1);
    check("c3_first_irq", 32'(t1 - t0), 32'(EXP_PS));
    bus_write(3, 0, 0);
    wait_irq(3, 40, t2);
    check("c3_irq_interval", 32'(t2 - t1), 32'(EXP_PS));
    bus_read(3, 4, rd); check("c3_prescale_rb", rd, 32'(EXP_PRESC));
    bus_write(3, 1, 32'h8);
    bus_write(3, 0, 0);

    // ch4: period truncated to 16 bits, then period 0 (TO every tick)
    bus_write(4, 2, 32'h12345);
    bus_read(4, 2, rd); check("c4_period_trunc", rd, 32'h2345);
    bus_write(4, 2, 0);
    bus_write(4, 1, 32'h7);
    t0 = cyc;
    wait_irq(4, 10, t1);
    check("c4_p0_first", 32'(t1 - t0), 32'd1);
    // status clear coincides with the next timeout; clear wins, so one is skipped
    bus_write(4, 0, 0);
    wait_irq(4, 10, t2);
    check("c4_clear_wins", 32'(t2 - t1), 32'd2);
    bus_write(4, 1, 32'h8);
    bus_write(4, 0, 0);
    check("c4_irq_off", 32'(irq_vec), 32'd0);

    // unmapped channel and offsets
    bus_write(5, 2, 32'h55);
    bus_write(0, 6, 32'hFF);
    bus_read(5, 2, rd); check("unmapped_ch_period", rd, 32'd0);
    bus_read(5, 0, rd); check("unmapped_ch_status", rd, 32'd0);
    bus_read(0, 6, rd); check("unmapped_off6", rd, 32'd0);
    bus_read(0, 5, rd); check("unmapped_off5", rd, 32'd0);
    bus_read(0, 2, rd); check("c0_period_intact", rd, 32'd9);
    bus_read(4, 2, rd); check("c4_period_intact", rd, 32'd0);
    bus_read(0, 1, rd); check("c0_control_intact", rd, 32'd8);

    // reset asserted mid-count on ch1
    bus_write(1, 2, 100);
    bus_write(1, 1, 32'h7);
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_readdata", readdata, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(1, 0, rd); check("midrst_c1_status", rd, 32'd0);
    bus_read(1, 1, rd); check("midrst_c1_control", rd, 32'd0);
    bus_read(1, 2, rd); check("midrst_c1_period", rd, 32'd49999);
    bus_read(1, 3, rd); check("midrst_c1_snapshot", rd, 32'd0);
    bus_read(0, 2, rd); check("midrst_c0_period", rd, 32'd49999);
    bus_read(3, 4, rd); check("midrst_c3_prescale", rd, 32'd0);
    bus_write(1, 3, 0);
    bus_read(1, 3, rd); check("midrst_c1_counter", rd, 32'd49999);
    repeat (120) @(posedge clk);
    #1 check("post_rst_no_irq", 32'(irq), 32'd0);
    bus_read(1, 0, rd); check("post_rst_no_to", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
